// File: rtl/decode_pipe_if.sv
// Bundle of decode-stage signals between the fetch/writeback side (master)
// and the decode pipeline register (slave).
//   master: drives decode fields, writeback port and pipeline controls
//   slave : decode_pipe, drives the registered decode results
// DATA_W and ADDR_W must match the decode_pipe instance (ADDR_W = log2(NREGS)).
interface decode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  // Decode inputs
  logic              in_valid;
  logic [ADDR_W-1:0] Rn;
  logic [ADDR_W-1:0] Rm;
  logic [ADDR_W-1:0] Rd;
  logic [1:0]        RegSrc;
  logic [DATA_W-1:0] PCPlus4;

  // Writeback port
  logic              WE3;
  logic [ADDR_W-1:0] WA3;
  logic [DATA_W-1:0] WD3;

  // Pipeline control
  logic              stall;
  logic              flush;

  // Registered decode results
  logic              out_valid;
  logic [DATA_W-1:0] RD1_q;
  logic [DATA_W-1:0] RD2_q;
  logic [ADDR_W-1:0] Rd_q;

  modport master (
    output in_valid, Rn, Rm, Rd, RegSrc, PCPlus4,
    output WE3, WA3, WD3,
    output stall, flush,
    input  out_valid, RD1_q, RD2_q, Rd_q
  );

  modport slave (
    input  in_valid, Rn, Rm, Rd, RegSrc, PCPlus4,
    input  WE3, WA3, WD3,
    input  stall, flush,
    output out_valid, RD1_q, RD2_q, Rd_q
  );
endinterface

// File: rtl/decode_pipe.sv
// Decode stage: register file read plus the decode/execute pipeline register.
//  - NREGS-1 writable registers; the top index (NREGS-1) reads as the PC
//    (PCPlus4 + PC_OFFSET) and ignores writes.
//  - Pipeline register is a two-state EMPTY/FULL machine with flush over stall.
//  - Synchronous active-high reset clears the register file and the pipeline.
// Optional feature: define DECODE_PIPE_BYPASS_EN to forward the writeback data
// to a same-cycle read of the register being written.
module decode_pipe #(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 16,
  parameter int PC_OFFSET = 4
) (
  input  logic         clk,
  input  logic         reset,
  decode_pipe_if.slave bus
);

  localparam int ADDR_W = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS - 1);

  // Elaboration-time sanity of the register count.
  if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("decode_pipe: NREGS must be a power of two and at least 4");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } pipe_state_e;

  // Register file: indices 0..NREGS-2 only; index NREGS-1 is the PC.
  logic [DATA_W-1:0] regs [NREGS-1];

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] pc_value;
  logic              write_hit;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;

  pipe_state_e       state;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [ADDR_W-1:0] rdest_q;

  assign pc_value  = bus.PCPlus4 + DATA_W'(PC_OFFSET);
  assign write_hit = bus.WE3 && (bus.WA3 != PC_IDX);

  // One read port: PC at the top index, optional write bypass, else the array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    if (addr == PC_IDX) begin
      value = pc_value;
    end else begin
      value = regs[addr];
`ifdef DECODE_PIPE_BYPASS_EN
      if (write_hit && (bus.WA3 == addr)) begin
        value = bus.WD3;
      end
`endif
    end
    return value;
  endfunction

  // Read address selection and register file read.
  // NOTE: every always_comb output gets a default assignment at the top so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ra1      = bus.Rn;
    ra2      = bus.Rm;
    if (bus.RegSrc[0]) begin
      ra1 = PC_IDX;
    end
    if (bus.RegSrc[1]) begin
      ra2 = bus.Rd;
    end
    rd1_data = read_port(ra1);
    rd2_data = read_port(ra2);
  end

  // Register file write; reset wins over a coincident write.
  // NOTE: the array is reset explicitly because architectural state must read
  // as zero after reset; this rules out a RAM macro, which is fine at this size.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[bus.WA3] <= bus.WD3;
    end
  end

  // Decode/execute pipeline register: reset > flush > stall > load.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rdest_q <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else if (!bus.stall) begin
      state   <= bus.in_valid ? FULL : EMPTY;
      rd1_q   <= rd1_data;
      rd2_q   <= rd2_data;
      rdest_q <= bus.Rd;
    end
  end

  // Registered results onto the interface.
  assign bus.out_valid = (state == FULL);
  assign bus.RD1_q     = rd1_q;
  assign bus.RD2_q     = rd2_q;
  assign bus.Rd_q      = rdest_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of registers, PC and read ports.
REQ-002 SHALL have parameter NREGS, default 16, register count; power of two, at least 4; ADDR_W = log2(NREGS).
REQ-003 SHALL have parameter PC_OFFSET, default 4, constant added to PCPlus4 to form the PC read value.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  decode inputs carry a valid instruction this cycle.
REQ-007 SHALL have ports Rn, Rm, Rd  input  ADDR_W  source 1, source 2 and destination register fields.
REQ-008 SHALL have port RegSrc  input  2  bit0 selects the PC register for RA1; bit1 selects Rd for RA2.
REQ-009 SHALL have port PCPlus4  input  DATA_W  fetch PC plus 4.
REQ-010 SHALL have ports WE3 (1), WA3 (ADDR_W), WD3 (DATA_W)  input  writeback enable, address, data.
REQ-011 SHALL have ports stall, flush  input  1  hold or invalidate the decode/execute pipeline register.
REQ-012 SHALL have ports out_valid (1), RD1_q, RD2_q (DATA_W), Rd_q (ADDR_W)  output  registered decode results.

Function
REQ-013 SHALL compute RA1 = all-ones (index NREGS-1) when RegSrc[0]=1, else Rn.
REQ-014 SHALL compute RA2 = Rd when RegSrc[1]=1, else Rm.
REQ-015 SHALL hold NREGS-1 writable registers, indices 0..NREGS-2.
REQ-016 SHALL return PCPlus4 + PC_OFFSET, modulo 2^DATA_W, when index NREGS-1 is read on either port.
REQ-017 SHALL write WD3 to register WA3 at the clock edge when WE3=1 and WA3 is not NREGS-1.
REQ-018 SHALL ignore writes with WA3 = NREGS-1: no register changes and no bypass.
REQ-019 SHALL write the register file regardless of stall, flush and in_valid.
REQ-020 SHALL, when flush=1 at an edge, clear out_valid to 0; data outputs hold their previous values.
REQ-021 SHALL, when stall=1 and flush=0 at an edge, hold out_valid, RD1_q, RD2_q and Rd_q.
REQ-022 SHALL, when stall=0 and flush=0 at an edge, load out_valid=in_valid, RD1_q/RD2_q from the read ports and Rd_q=Rd.
REQ-023 SHALL give flush priority over stall when both are asserted.
REQ-024 SHALL produce outputs with a latency of exactly one cycle from the decode inputs.
REQ-025 SHALL keep pipeline state to two states, EMPTY (out_valid=0) and FULL (out_valid=1), transitioning only per REQ-020..REQ-022.

Reset
REQ-026 SHALL, when reset=1 at an edge, clear all writable registers, out_valid, RD1_q, RD2_q and Rd_q to 0.
REQ-027 SHALL give reset priority over WE3, stall and flush; a write coincident with reset is discarded.
REQ-028 SHALL apply reset mid-stall identically; the stall releases with out_valid=0.

Configuration
REQ-029 SHALL, with macro DECODE_PIPE_BYPASS_EN defined, forward WD3 to any read port whose address equals WA3 while WE3=1 and WA3 is not NREGS-1, in the same cycle.
REQ-030 SHALL, without DECODE_PIPE_BYPASS_EN, return the pre-write register value on a same-cycle read/write collision.

Verification
REQ-031 SHALL cover reset: write R3=0x55 and assert reset -> next cycle out_valid=0, RD1_q=0, RD2_q=0, Rd_q=0, and a later read of R3 returns 0.
REQ-032 SHALL cover the PC read: PCPlus4=0x100, RegSrc=01, in_valid=1 -> next cycle RD1_q=0x104; PCPlus4=0xFFFFFFFC -> RD1_q=0x00000000.
REQ-033 SHALL cover the collision: WE3=1, WA3=2, WD3=0xDEAD with Rn=2 -> RD1_q=0xDEAD with the macro defined, or the old R2 value without it.
REQ-034 SHALL cover stall and flush: a FULL register with RD2_q=0x7, stall=1 for 3 cycles -> RD2_q stays 0x7; then stall=1 with flush=1 -> out_valid=0.
REQ-035 SHALL cover PC-write suppression and RegSrc[1]: WE3=1 with WA3=15 -> no register changes; RegSrc=10 with Rd=5 holding 0x9 -> RD2_q=0x9.
REQ-036 SHALL cover parameters: NREGS=8, DATA_W=16 -> index 7 reads PCPlus4+4 truncated to 16 bits, and indices 0..6 are writable.
